// File: rtl/pq_pkg.sv
// Shared types and default sizing for the sorted shift-register priority queue.
package pq_pkg;

    localparam int PQ_DATA_W = 16;
    localparam int PQ_DEPTH  = 8;

    typedef logic [PQ_DATA_W-1:0] key_t;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        LOAD_NEW = 2'd1,
        SHIFT_R  = 2'd2,
        SHIFT_L  = 2'd3
    } cell_op_t;

endpackage

// File: rtl/pq_cell.sv
// One queue entry: key and valid flops, an enq_data < key comparator, and a
// next-value mux choosing between hold, new key, left neighbour or right neighbour.
module pq_cell
    import pq_pkg::*;
#(
    parameter int DATA_W = PQ_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  cell_op_t          op,
    input  logic [DATA_W-1:0] enq_data,
    input  logic [DATA_W-1:0] left_key,
    input  logic              left_valid,
    input  logic [DATA_W-1:0] right_key,
    input  logic              right_valid,
    output logic [DATA_W-1:0] key,
    output logic              valid,
    output logic              lt
);

    logic [DATA_W-1:0] key_r;
    logic              valid_r;
    logic [DATA_W-1:0] key_nxt_s;
    logic              valid_nxt_s;

    assign lt = (enq_data < key_r);

    // Next-value mux driven by the per-cell operation
    always_comb begin
        key_nxt_s   = key_r;
        valid_nxt_s = valid_r;
        case (op)
            HOLD: begin
                key_nxt_s   = key_r;
                valid_nxt_s = valid_r;
            end
            LOAD_NEW: begin
                key_nxt_s   = enq_data;
                valid_nxt_s = 1'b1;
            end
            SHIFT_R: begin
                key_nxt_s   = left_key;
                valid_nxt_s = left_valid;
            end
            SHIFT_L: begin
                key_nxt_s   = right_key;
                valid_nxt_s = right_valid;
            end
            default: begin
                key_nxt_s   = key_r;
                valid_nxt_s = valid_r;
            end
        endcase
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (rst) begin
            key_r   <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            key_r   <= key_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign key   = key_r;
    assign valid = valid_r;

endmodule

// File: rtl/pq_shift_queue.sv
// Sorted shift-register priority queue: minimum key at entry 0, equal keys
// leave in arrival order, one enqueue and/or one dequeue per cycle.
module pq_shift_queue
    import pq_pkg::*;
#(
    parameter int DATA_W = PQ_DATA_W,
    parameter int DEPTH  = PQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid,
    input  logic [DATA_W-1:0]          enq_data,
    output logic                       enq_ready,
    output logic                       deq_valid,
    output logic [DATA_W-1:0]          deq_data,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [DATA_W-1:0] key_s [DEPTH];
    logic [DEPTH-1:0]  valid_s;
    logic [DEPTH-1:0]  lt_s;
    logic [DEPTH-1:0]  ge_s;
    logic [DEPTH+1:0]  ge_pad_s;
    cell_op_t          op_s [DEPTH];
    logic [CW-1:0]     count_r;
    logic              enq_fire_s;
    logic              deq_fire_s;

    assign enq_ready  = (count_r < DEPTH_C);
    assign deq_valid  = (count_r != {CW{1'b0}});
    assign enq_fire_s = enq_valid & enq_ready;
    assign deq_fire_s = deq_valid & deq_ready;

    // ge_s marks cells that stay ahead of the new key; it is a contiguous prefix
    // because the valid entries are sorted, so its length is the insert position.
    assign ge_s     = valid_s & ~lt_s;
    assign ge_pad_s = {1'b0, ge_s, 1'b1};

    // Per-cell operation from the prefix vector and the handshakes
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            op_s[i] = HOLD;
            if (enq_fire_s && !deq_fire_s) begin
                if (ge_s[i]) begin
                    op_s[i] = HOLD;
                end else if (ge_pad_s[i]) begin
                    op_s[i] = LOAD_NEW;
                end else begin
                    op_s[i] = SHIFT_R;
                end
            end else if (enq_fire_s && deq_fire_s) begin
                // Head leaves: cells before the slot move left, the key lands at p-1 (or 0)
                if (ge_pad_s[i+2]) begin
                    op_s[i] = SHIFT_L;
                end else if (ge_s[i]) begin
                    op_s[i] = LOAD_NEW;
                end else if (i == 0) begin
                    op_s[i] = LOAD_NEW;
                end else begin
                    op_s[i] = HOLD;
                end
            end else if (deq_fire_s) begin
                op_s[i] = SHIFT_L;
            end else begin
                op_s[i] = HOLD;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        logic [DATA_W-1:0] left_key_s;
        logic              left_valid_s;
        logic [DATA_W-1:0] right_key_s;
        logic              right_valid_s;

        if (g == 0) begin : g_first
            assign left_key_s   = {DATA_W{1'b0}};
            assign left_valid_s = 1'b0;
        end else begin : g_inner_l
            assign left_key_s   = key_s[g-1];
            assign left_valid_s = valid_s[g-1];
        end

        if (g == DEPTH - 1) begin : g_last
            assign right_key_s   = {DATA_W{1'b0}};
            assign right_valid_s = 1'b0;
        end else begin : g_inner_r
            assign right_key_s   = key_s[g+1];
            assign right_valid_s = valid_s[g+1];
        end

        pq_cell #(
            .DATA_W(DATA_W)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .op         (op_s[g]),
            .enq_data   (enq_data),
            .left_key   (left_key_s),
            .left_valid (left_valid_s),
            .right_key  (right_key_s),
            .right_valid(right_valid_s),
            .key        (key_s[g]),
            .valid      (valid_s[g]),
            .lt         (lt_s[g])
        );
    end

    // Occupancy counter
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    assign count    = count_r;
    assign deq_data = key_s[0];

endmodule

// File: tb/tb_pq_shift_queue.sv
// Directed and randomised checks of pq_shift_queue against hand-computed values
// and a sorted-list reference model.
module tb_pq_shift_queue;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic              enq_valid;
    logic [DATA_W-1:0] enq_data;
    logic              enq_ready;
    logic              deq_valid;
    logic [DATA_W-1:0] deq_data;
    logic              deq_ready;
    logic [3:0]        count;

    int n_tests;
    int n_fail;
    int model_q[$];

    pq_shift_queue #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enq_valid(enq_valid),
        .enq_data (enq_data),
        .enq_ready(enq_ready),
        .deq_valid(deq_valid),
        .deq_data (deq_data),
        .deq_ready(deq_ready),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [15:0] k);
        enq_valid = 1'b1;
        enq_data  = k;
        deq_ready = 1'b0;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic deq();
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
    endtask

    task automatic both(input logic [15:0] k);
        enq_valid = 1'b1;
        enq_data  = k;
        deq_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_deq_valid"}, 32'(deq_valid), 32'd0);
        chk({tag, "_deq_data"}, 32'(deq_data), 32'd0);
        chk({tag, "_enq_ready"}, 32'(enq_ready), 32'd1);
    endtask

    initial begin
        int exp_seq[4];
        int idx;
        logic ev, dr, ef, df;
        logic [15:0] kd;

        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        enq_valid = 1'b0;
        enq_data  = 16'd0;
        deq_ready = 1'b0;

        // Reset then idle
        tick();
        rst = 1'b0;
        chk_reset_state("reset");
        tick();
        chk_reset_state("idle");

        // Ordering with a tie
        enq(16'd5);
        chk("first_enq_valid", 32'(deq_valid), 32'd1);
        chk("first_enq_data", 32'(deq_data), 32'd5);
        enq(16'd2);
        enq(16'd9);
        enq(16'd2);
        chk("four_count", 32'(count), 32'd4);
        exp_seq = '{2, 2, 5, 9};
        for (int i = 0; i < 4; i++) begin
            chk("order_data", 32'(deq_data), 32'(exp_seq[i]));
            deq();
            chk("order_count", 32'(count), 32'(3 - i));
        end
        chk("drained_valid", 32'(deq_valid), 32'd0);
        chk("drained_data", 32'(deq_data), 32'd0);

        // Reset mid-stream with a live handshake
        enq(16'd7);
        enq(16'd3);
        enq(16'd4);
        chk("mid_count", 32'(count), 32'd3);
        rst       = 1'b1;
        enq_valid = 1'b1;
        enq_data  = 16'd1;
        deq_ready = 1'b1;
        tick();
        rst       = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        chk_reset_state("mid_reset");

        // Fill, then full with simultaneous request: only dequeue fires
        for (int i = 1; i <= 8; i++) enq(16'(i * 10));
        chk("full_count", 32'(count), 32'd8);
        chk("full_enq_ready", 32'(enq_ready), 32'd0);
        chk("full_head", 32'(deq_data), 32'd10);
        both(16'd1);
        chk("full_both_count", 32'(count), 32'd7);
        chk("full_both_head", 32'(deq_data), 32'd20);
        chk("full_both_ready", 32'(enq_ready), 32'd1);
        for (int i = 2; i <= 8; i++) begin
            chk("full_drain", 32'(deq_data), 32'(i * 10));
            deq();
        end
        chk("full_drain_count", 32'(count), 32'd0);

        // Simultaneous enqueue/dequeue on {3,7,12}
        enq(16'd12);
        enq(16'd3);
        enq(16'd7);
        both(16'd5);
        chk("both5_data", 32'(deq_data), 32'd5);
        chk("both5_count", 32'(count), 32'd3);
        both(16'd20);
        chk("both20_data", 32'(deq_data), 32'd7);
        chk("both20_count", 32'(count), 32'd3);
        both(16'd1);
        chk("both1_data", 32'(deq_data), 32'd1);
        exp_seq = '{1, 12, 20, 0};
        for (int i = 0; i < 3; i++) begin
            chk("both_drain", 32'(deq_data), 32'(exp_seq[i]));
            deq();
        end
        chk("both_drain_count", 32'(count), 32'd0);

        // Empty with both requests: only the enqueue fires
        both(16'd4);
        chk("empty_both_count", 32'(count), 32'd1);
        chk("empty_both_data", 32'(deq_data), 32'd4);
        deq();

        // Random traffic against a sorted-list model
        model_q.delete();
        for (int c = 0; c < 10000; c++) begin
            ev = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 2) == 0 ? 0 : 1);
            if (c % 1000 >= 500) dr = 1'($urandom_range(0, 3) == 0);
            kd = 16'($urandom_range(0, 15));
            ef = ev && (model_q.size() < DEPTH);
            df = dr && (model_q.size() > 0);
            enq_valid = ev;
            enq_data  = kd;
            deq_ready = dr;
            chk("rnd_count", 32'(count), 32'(model_q.size()));
            chk("rnd_enq_ready", 32'(enq_ready), 32'(model_q.size() < DEPTH));
            chk("rnd_head", 32'(deq_data), (model_q.size() > 0) ? 32'(model_q[0]) : 32'd0);
            if (df) model_q.pop_front();
            if (ef) begin
                idx = model_q.size();
                for (int i = 0; i < model_q.size(); i++) begin
                    if (int'(kd) < model_q[i]) begin
                        idx = i;
                        break;
                    end
                end
                model_q.insert(idx, int'(kd));
            end
            tick();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        chk("rnd_final_count", 32'(count), 32'(model_q.size()));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
